// File: rtl/pipeline_run_ctrl_if.sv
// Command channel from the debug unit into pipeline_run_ctrl.
// A command transfers on the rising clock edge where i_cmd_valid and o_cmd_ready are both high; the master holds i_cmd/i_step_n stable while valid is high.
interface pipeline_run_ctrl_if #(
  parameter int STEP_SIZE = 16
);
  logic                 i_cmd_valid;
  logic                 o_cmd_ready;
  logic [1:0]           i_cmd;
  logic [STEP_SIZE-1:0] i_step_n;

  modport master (output i_cmd_valid, i_cmd, i_step_n, input o_cmd_ready);
  modport slave  (input i_cmd_valid, i_cmd, i_step_n, output o_cmd_ready);
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/step/stop controller driving the shared pipeline-register enable.
// Optional watchdog (and its WDOG_LIMIT parameter) exists only with PIPELINE_RUN_CTRL_WATCHDOG_EN.
module pipeline_run_ctrl #(
  parameter int CNT_SIZE  = 32,
  parameter int STEP_SIZE = 16
`ifdef PIPELINE_RUN_CTRL_WATCHDOG_EN
  , parameter logic [31:0] WDOG_LIMIT = 32'h00FF_FFFF
`endif
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  pipeline_run_ctrl_if.slave  cmd_if,
  input  logic                i_halt,
  output logic                o_pipeline_enable,
  output logic [1:0]          o_state,
  output logic [CNT_SIZE-1:0] o_cycle_count,
  output logic                o_done,
  output logic                o_cmd_error,
  output logic                o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_STOP  = 2'b11;

  state_t               state;
  logic                 enable;
  logic [CNT_SIZE-1:0]  count;
  logic [STEP_SIZE-1:0] step_cnt;
  logic                 done;
  logic                 cmd_error;
  logic                 accept;
  logic                 clear_cmd;
  logic                 halt_evt;
  logic                 wdog_hit;
  logic [STEP_SIZE-1:0] step_load;

  assign cmd_if.o_cmd_ready = (state != S_STEP);
  assign accept    = cmd_if.i_cmd_valid && cmd_if.o_cmd_ready;
  assign clear_cmd = accept && (cmd_if.i_cmd == CMD_CLEAR);
  // Halt only means something on a cycle the pipeline actually advanced.
  assign halt_evt  = enable && i_halt;
  assign step_load = (cmd_if.i_step_n == '0) ? STEP_SIZE'(1) : cmd_if.i_step_n;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_IDLE;
      enable    <= 1'b0;
      count     <= '0;
      step_cnt  <= '0;
      done      <= 1'b0;
      cmd_error <= 1'b0;
    end else begin
      done      <= 1'b0;
      cmd_error <= 1'b0;

      if (clear_cmd)
        count <= '0;
      else if (enable && (count != '1))
        count <= count + CNT_SIZE'(1);

      if (halt_evt) begin
        state    <= S_HALTED;
        enable   <= 1'b0;
        step_cnt <= '0;
        done     <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (accept && (cmd_if.i_cmd == CMD_RUN)) begin
              state  <= S_RUN;
              enable <= 1'b1;
            end else if (accept && (cmd_if.i_cmd == CMD_STEP)) begin
              state    <= S_STEP;
              enable   <= 1'b1;
              step_cnt <= step_load;
            end
          end
          S_RUN: begin
            if (wdog_hit || (accept && (cmd_if.i_cmd == CMD_STOP))) begin
              state  <= S_IDLE;
              enable <= 1'b0;
              done   <= 1'b1;
            end else if (accept && (cmd_if.i_cmd != CMD_CLEAR)) begin
              cmd_error <= 1'b1;
            end
          end
          S_STEP: begin
            if (step_cnt <= STEP_SIZE'(1)) begin
              state    <= S_IDLE;
              enable   <= 1'b0;
              step_cnt <= '0;
              done     <= 1'b1;
            end else begin
              step_cnt <= step_cnt - STEP_SIZE'(1);
            end
          end
          default: begin
            if (clear_cmd)
              state <= S_IDLE;
            else if (accept)
              cmd_error <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef PIPELINE_RUN_CTRL_WATCHDOG_EN
  logic [31:0] run_len;
  logic        timeout;

  // run_len holds the number of completed RUN cycles; it is zero on the first one.
  assign wdog_hit = (state == S_RUN) && ((run_len + 32'd1) == WDOG_LIMIT);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      run_len <= '0;
      timeout <= 1'b0;
    end else begin
      run_len <= (state == S_RUN) ? run_len + 32'd1 : 32'd0;
      if (wdog_hit && !halt_evt)
        timeout <= 1'b1;
      else if (clear_cmd)
        timeout <= 1'b0;
    end
  end

  assign o_timeout = timeout;
`else
  assign wdog_hit  = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_pipeline_enable = enable;
  assign o_state           = state;
  assign o_cycle_count     = count;
  assign o_done            = done;
  assign o_cmd_error       = cmd_error;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: reference model checked every cycle plus literal checkpoints.
module tb_pipeline_run_ctrl;
  localparam logic [1:0] CLR  = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] STP  = 2'b10;
  localparam logic [1:0] STOP = 2'b11;
  localparam int LIMIT = 20;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic        en;
  logic [1:0]  st;
  logic [31:0] cnt;
  logic        done;
  logic        err;
  logic        tmo;

  int vectors     = 0;
  int miscompares = 0;

  pipeline_run_ctrl_if #(.STEP_SIZE(16)) bus ();

  pipeline_run_ctrl #(
    .CNT_SIZE(32),
    .STEP_SIZE(16)
`ifdef PIPELINE_RUN_CTRL_WATCHDOG_EN
    , .WDOG_LIMIT(32'(LIMIT))
`endif
  ) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .cmd_if           (bus),
    .i_halt           (halt),
    .o_pipeline_enable(en),
    .o_state          (st),
    .o_cycle_count    (cnt),
    .o_done           (done),
    .o_cmd_error      (err),
    .o_timeout        (tmo)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: m_left = 0 stopped, -1 free running, >0 enabled cycles still owed by a STEP.
  int          m_left;
  bit          m_halted;
  logic [31:0] m_count;
  logic [31:0] m_runlen;
  bit          m_done;
  bit          m_err;
  bit          m_to;

  always @(posedge clk or negedge rst_n) begin : model
    int          left;
    bit          halted, d, e, t, act, acc;
    logic [31:0] c;
    if (!rst_n) begin
      m_left   <= 0;
      m_halted <= 1'b0;
      m_count  <= '0;
      m_runlen <= '0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
      m_to     <= 1'b0;
    end else begin
      left = m_left; halted = m_halted; c = m_count; t = m_to; d = 1'b0; e = 1'b0;
      act = (left != 0);
      acc = bus.i_cmd_valid && !(left > 0);
      if (acc && bus.i_cmd == CLR) begin
        c = '0;
        t = 1'b0;
      end else if (act && c != 32'hFFFF_FFFF) begin
        c = c + 32'd1;
      end
      if (act && halt) begin
        halted = 1'b1; left = 0; d = 1'b1;
      end
`ifdef PIPELINE_RUN_CTRL_WATCHDOG_EN
      else if (left < 0 && m_runlen + 32'd1 == 32'(LIMIT)) begin
        left = 0; d = 1'b1; t = 1'b1;
      end
`endif
      else if (acc) begin
        case (bus.i_cmd)
          RUN:  if (halted || left < 0) e = 1'b1; else left = -1;
          STP:  if (halted || left < 0) e = 1'b1;
                else left = (bus.i_step_n == 0) ? 1 : int'(bus.i_step_n);
          STOP: if (halted) e = 1'b1; else if (left < 0) begin left = 0; d = 1'b1; end
          default: halted = 1'b0;
        endcase
      end else if (left > 0) begin
        if (left == 1) d = 1'b1;
        left = left - 1;
      end
      m_runlen <= (m_left < 0) ? m_runlen + 32'd1 : 32'd0;
      m_left   <= left;
      m_halted <= halted;
      m_count  <= c;
      m_done   <= d;
      m_err    <= e;
      m_to     <= t;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // scoreboard: every output against the model, away from the active edge
  always @(negedge clk) begin
    logic [1:0] exp_state;
    exp_state = m_halted ? 2'b11 : (m_left < 0) ? 2'b01 : (m_left > 0) ? 2'b10 : 2'b00;
    check("enable", 32'(en), 32'(m_left != 0));
    check("state", 32'(st), 32'(exp_state));
    check("ready", 32'(bus.o_cmd_ready), 32'(!(m_left > 0)));
    check("count", cnt, m_count);
    check("done", 32'(done), 32'(m_done));
    check("cmd_error", 32'(err), 32'(m_err));
    check("timeout", 32'(tmo), 32'(m_to));
  end

  // driver: entered and left at posedge+2
  task automatic cycle(input logic v, input logic [1:0] c, input logic [15:0] n, input logic h);
    bus.i_cmd_valid = v;
    bus.i_cmd       = c;
    bus.i_step_n    = n;
    halt            = h;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, CLR, 16'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_cmd_valid = 1'b0; bus.i_cmd = CLR; bus.i_step_n = '0; halt = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_enable", 32'(en), 32'd0);
    check("rst_count", cnt, 32'd0);
    check("rst_state", 32'(st), 32'd0);
    check("rst_ready", 32'(bus.o_cmd_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;

    // RUN then STOP on the 10th enabled edge
    cycle(1'b1, RUN, 16'd0, 1'b0);
    check("run_enable", 32'(en), 32'd1);
    check("run_state", 32'(st), 32'd1);
    idle(9);
    cycle(1'b1, STOP, 16'd0, 1'b0);
    check("stop_count", cnt, 32'd10);
    check("stop_enable", 32'(en), 32'd0);
    check("stop_done", 32'(done), 32'd1);
    check("stop_state", 32'(st), 32'd0);
    idle(1);
    check("done_pulse_end", 32'(done), 32'd0);
    cycle(1'b1, CLR, 16'd0, 1'b0);
    check("clear_idle", cnt, 32'd0);

    // STEP 3, then STEP 0
    cycle(1'b1, STP, 16'd3, 1'b0);
    check("step_ready", 32'(bus.o_cmd_ready), 32'd0);
    check("step_state", 32'(st), 32'd2);
    cycle(1'b1, STOP, 16'd0, 1'b0);
    idle(1);
    check("step_still_on", 32'(en), 32'd1);
    idle(1);
    check("step3_count", cnt, 32'd3);
    check("step3_done", 32'(done), 32'd1);
    check("step3_enable", 32'(en), 32'd0);
    cycle(1'b1, STP, 16'd0, 1'b0);
    idle(1);
    check("step0_count", cnt, 32'd4);
    check("step0_state", 32'(st), 32'd0);

    // halt with simultaneous STOP on 5th enabled edge
    cycle(1'b1, CLR, 16'd0, 1'b0);
    cycle(1'b1, RUN, 16'd0, 1'b0);
    idle(4);
    cycle(1'b1, STOP, 16'd0, 1'b1);
    check("halt_state", 32'(st), 32'd3);
    check("halt_count", cnt, 32'd5);
    check("halt_err", 32'(err), 32'd0);
    check("halt_done", 32'(done), 32'd1);
    cycle(1'b1, RUN, 16'd0, 1'b0);
    check("halted_run_err", 32'(err), 32'd1);
    cycle(1'b1, CLR, 16'd0, 1'b0);
    check("halted_clear_state", 32'(st), 32'd0);
    check("halted_clear_count", cnt, 32'd0);

    // STEP 8 halted on its 4th enabled cycle; halt ignored in IDLE
    cycle(1'b1, STP, 16'd8, 1'b0);
    idle(3);
    cycle(1'b0, CLR, 16'd0, 1'b1);
    check("stephalt_state", 32'(st), 32'd3);
    check("stephalt_count", cnt, 32'd4);
    cycle(1'b1, CLR, 16'd0, 1'b0);
    cycle(1'b0, CLR, 16'd0, 1'b1);
    cycle(1'b0, CLR, 16'd0, 1'b1);
    check("idle_halt_state", 32'(st), 32'd0);

    // errors and CLEAR while running
    cycle(1'b1, RUN, 16'd0, 1'b0);
    cycle(1'b1, STP, 16'd5, 1'b0);
    check("run_step_err", 32'(err), 32'd1);
    idle(2);
    cycle(1'b1, CLR, 16'd0, 1'b0);
    check("run_clear_count", cnt, 32'd0);
    idle(1);
    check("run_after_clear", cnt, 32'd1);
    cycle(1'b1, STOP, 16'd0, 1'b0);
    check("run_stop2_count", cnt, 32'd2);

    // asynchronous reset between edges
    cycle(1'b1, RUN, 16'd0, 1'b0);
    idle(3);
    #1 rst_n = 1'b0;
    #1;
    check("async_enable", 32'(en), 32'd0);
    check("async_count", cnt, 32'd0);
    check("async_state", 32'(st), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;

`ifdef PIPELINE_RUN_CTRL_WATCHDOG_EN
    cycle(1'b1, RUN, 16'd0, 1'b0);
    idle(LIMIT);
    check("wdog_state", 32'(st), 32'd0);
    check("wdog_timeout", 32'(tmo), 32'd1);
    check("wdog_count", cnt, 32'(LIMIT));
    idle(2);
    check("wdog_sticky", 32'(tmo), 32'd1);
    cycle(1'b1, CLR, 16'd0, 1'b0);
    check("wdog_clear", 32'(tmo), 32'd0);
`else
    cycle(1'b1, RUN, 16'd0, 1'b0);
    idle(LIMIT + 2);
    check("no_wdog_state", 32'(st), 32'd1);
    check("no_wdog_timeout", 32'(tmo), 32'd0);
    cycle(1'b1, STOP, 16'd0, 1'b0);
`endif
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
